// File: rtl/operand_issue.sv
// Single-entry operand collection and issue stage between decode and execute.
// Reads rs1/rs2 from the register file, snoops write-back for pending operands, issues once both resolve.
//
// state   | meaning
// IDLE    | empty, accepting a decoded instruction
// WAIT    | instruction held, collecting unresolved operands
// ISSUE   | operands resolved, presenting to execute
module operand_issue #(
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,

  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic                 dec_rs1_en,
  input  logic                 dec_rs2_en,
  input  logic [4:0]           dec_rs1_addr,
  input  logic [4:0]           dec_rs2_addr,
  input  logic                 dec_rd_en,
  input  logic [4:0]           dec_rd_addr,
  input  logic [31:0]          dec_payload,

  output logic                 rf_rd_ch0_en,
  output logic                 rf_rd_ch1_en,
  output logic [4:0]           rf_rd_ch0_addr,
  output logic [4:0]           rf_rd_ch1_addr,
  input  logic [31:0]          rf_rd_ch0_data,
  input  logic [31:0]          rf_rd_ch1_data,
  input  logic                 rf_rd_ch0_dirty,
  input  logic                 rf_rd_ch1_dirty,
  input  logic [TAG_WIDTH-1:0] rf_rd_ch0_tag,
  input  logic [TAG_WIDTH-1:0] rf_rd_ch1_tag,

  output logic                 rf_invalid_en,
  output logic [4:0]           rf_invalid_addr,
  input  logic [TAG_WIDTH-1:0] rf_new_tag,

  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [TAG_WIDTH-1:0] wb_tag,
  input  logic [31:0]          wb_data,

  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [31:0]          iss_rs1_data,
  output logic [31:0]          iss_rs2_data,
  output logic                 iss_rd_en,
  output logic [4:0]           iss_rd_addr,
  output logic [TAG_WIDTH-1:0] iss_rd_tag,
  output logic [31:0]          iss_payload
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]  state_q, state_d;

  logic        rs1_en_q, rs2_en_q;
  logic [4:0]  rs1_addr_q, rs2_addr_q;
  logic        rd_en_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] payload_q;
  logic        rs1_rdy_q, rs2_rdy_q;
  logic [31:0] rs1_data_q, rs2_data_q;

  logic        accept;
  logic        handshake;
  logic        rs1_res, rs2_res;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_done, rs2_done;

  assign iss_valid = (state_q == S_ISSUE);
  assign handshake = iss_valid & iss_ready & ~flush;

  always_comb begin
    dec_ready = 1'b0;
    case (state_q)
      S_IDLE:  dec_ready = ~flush;
      S_ISSUE: dec_ready = iss_ready & ~flush;
      default: dec_ready = 1'b0;
    endcase
  end

  assign accept = dec_valid & dec_ready;

  // Priority: unused or x0 operand, clean register, then matching write-back forward.
  always_comb begin
    rs1_res = 1'b0;
    rs1_val = 32'd0;
    if (!rs1_en_q || (rs1_addr_q == 5'd0)) begin
      rs1_res = 1'b1;
    end else if (!rf_rd_ch0_dirty) begin
      rs1_res = 1'b1;
      rs1_val = rf_rd_ch0_data;
    end else if (wb_en && (wb_addr == rs1_addr_q) && (wb_tag == rf_rd_ch0_tag)) begin
      rs1_res = 1'b1;
      rs1_val = wb_data;
    end
  end

  always_comb begin
    rs2_res = 1'b0;
    rs2_val = 32'd0;
    if (!rs2_en_q || (rs2_addr_q == 5'd0)) begin
      rs2_res = 1'b1;
    end else if (!rf_rd_ch1_dirty) begin
      rs2_res = 1'b1;
      rs2_val = rf_rd_ch1_data;
    end else if (wb_en && (wb_addr == rs2_addr_q) && (wb_tag == rf_rd_ch1_tag)) begin
      rs2_res = 1'b1;
      rs2_val = wb_data;
    end
  end

  assign rs1_done = rs1_rdy_q | rs1_res;
  assign rs2_done = rs2_rdy_q | rs2_res;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rs1_done && rs2_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) state_d = dec_valid ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs1_en_q   <= 1'b0;
      rs2_en_q   <= 1'b0;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= 5'd0;
      payload_q  <= 32'd0;
      rs1_rdy_q  <= 1'b0;
      rs2_rdy_q  <= 1'b0;
      rs1_data_q <= 32'd0;
      rs2_data_q <= 32'd0;
    end else if (accept) begin
      rs1_en_q   <= dec_rs1_en;
      rs2_en_q   <= dec_rs2_en;
      rs1_addr_q <= dec_rs1_addr;
      rs2_addr_q <= dec_rs2_addr;
      rd_en_q    <= dec_rd_en;
      rd_addr_q  <= dec_rd_addr;
      payload_q  <= dec_payload;
      rs1_rdy_q  <= 1'b0;
      rs2_rdy_q  <= 1'b0;
      rs1_data_q <= 32'd0;
      rs2_data_q <= 32'd0;
    end else if ((state_q == S_WAIT) && !flush) begin
      // A resolved operand is frozen so later write-backs cannot overwrite it.
      if (!rs1_rdy_q && rs1_res) begin
        rs1_rdy_q  <= 1'b1;
        rs1_data_q <= rs1_val;
      end
      if (!rs2_rdy_q && rs2_res) begin
        rs2_rdy_q  <= 1'b1;
        rs2_data_q <= rs2_val;
      end
    end
  end

  assign rf_rd_ch0_en   = (state_q == S_WAIT) & rs1_en_q & ~rs1_rdy_q;
  assign rf_rd_ch1_en   = (state_q == S_WAIT) & rs2_en_q & ~rs2_rdy_q;
  assign rf_rd_ch0_addr = rs1_addr_q;
  assign rf_rd_ch1_addr = rs2_addr_q;

  assign rf_invalid_en   = handshake & rd_en_q & (rd_addr_q != 5'd0);
  assign rf_invalid_addr = rd_addr_q;

  // The tag is only meaningful in the handshake cycle when rd is actually claimed.
  assign iss_rd_tag   = rf_invalid_en ? rf_new_tag : '0;
  assign iss_rs1_data = rs1_data_q;
  assign iss_rs2_data = rs2_data_q;
  assign iss_rd_en    = rd_en_q;
  assign iss_rd_addr  = rd_addr_q;
  assign iss_payload  = payload_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue with a small register-file scoreboard model.
module tb_operand_issue;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        dec_valid, dec_ready;
  logic        dec_rs1_en, dec_rs2_en;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr;
  logic        dec_rd_en;
  logic [4:0]  dec_rd_addr;
  logic [31:0] dec_payload;
  logic        rf_rd_ch0_en, rf_rd_ch1_en;
  logic [4:0]  rf_rd_ch0_addr, rf_rd_ch1_addr;
  logic [31:0] rf_rd_ch0_data, rf_rd_ch1_data;
  logic        rf_rd_ch0_dirty, rf_rd_ch1_dirty;
  logic [1:0]  rf_rd_ch0_tag, rf_rd_ch1_tag;
  logic        rf_invalid_en;
  logic [4:0]  rf_invalid_addr;
  logic [1:0]  rf_new_tag;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [1:0]  wb_tag;
  logic [31:0] wb_data;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_rs1_data, iss_rs2_data;
  logic        iss_rd_en;
  logic [4:0]  iss_rd_addr;
  logic [1:0]  iss_rd_tag;
  logic [31:0] iss_payload;

  logic [31:0] rf_val   [32];
  logic        rf_dirty [32];
  logic [1:0]  rf_tag   [32];

  int n_tests = 0;
  int n_fail  = 0;

  operand_issue #(.TAG_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_en(dec_rd_en), .dec_rd_addr(dec_rd_addr), .dec_payload(dec_payload),
    .rf_rd_ch0_en(rf_rd_ch0_en), .rf_rd_ch1_en(rf_rd_ch1_en),
    .rf_rd_ch0_addr(rf_rd_ch0_addr), .rf_rd_ch1_addr(rf_rd_ch1_addr),
    .rf_rd_ch0_data(rf_rd_ch0_data), .rf_rd_ch1_data(rf_rd_ch1_data),
    .rf_rd_ch0_dirty(rf_rd_ch0_dirty), .rf_rd_ch1_dirty(rf_rd_ch1_dirty),
    .rf_rd_ch0_tag(rf_rd_ch0_tag), .rf_rd_ch1_tag(rf_rd_ch1_tag),
    .rf_invalid_en(rf_invalid_en), .rf_invalid_addr(rf_invalid_addr), .rf_new_tag(rf_new_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr), .iss_rd_tag(iss_rd_tag),
    .iss_payload(iss_payload)
  );

  assign rf_rd_ch0_data  = rf_val[rf_rd_ch0_addr];
  assign rf_rd_ch1_data  = rf_val[rf_rd_ch1_addr];
  assign rf_rd_ch0_dirty = rf_dirty[rf_rd_ch0_addr];
  assign rf_rd_ch1_dirty = rf_dirty[rf_rd_ch1_addr];
  assign rf_rd_ch0_tag   = rf_tag[rf_rd_ch0_addr];
  assign rf_rd_ch1_tag   = rf_tag[rf_rd_ch1_addr];
  assign rf_new_tag      = rf_tag[rf_invalid_addr] + 2'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: register-file model applies the write-back and invalidate seen before the edge.
  task automatic step();
    logic       inv, w;
    logic [4:0] ia, wa;
    logic [1:0] nt, wt;
    logic [31:0] wd;
    #1;
    inv = rf_invalid_en; ia = rf_invalid_addr; nt = rf_new_tag;
    w = wb_en; wa = wb_addr; wt = wb_tag; wd = wb_data;
    @(posedge clk);
    #1;
    if (w && (wa != 5'd0) && (wt == rf_tag[wa])) begin
      rf_val[wa]   = wd;
      rf_dirty[wa] = 1'b0;
    end
    if (inv) begin
      rf_tag[ia]   = nt;
      rf_dirty[ia] = 1'b1;
    end
    #1;
  endtask

  task automatic dec_put(input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                         input logic rde, input logic [4:0] rd, input logic [31:0] pl);
    dec_valid = 1'b1;
    dec_rs1_en = r1e; dec_rs1_addr = r1;
    dec_rs2_en = r2e; dec_rs2_addr = r2;
    dec_rd_en = rde; dec_rd_addr = rd;
    dec_payload = pl;
  endtask

  task automatic wb_put(input logic en, input logic [4:0] a, input logic [1:0] t, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_tag = t; wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_val[i] = 32'd0; rf_dirty[i] = 1'b0; rf_tag[i] = 2'd0;
    end
    rf_val[5] = 32'h11;
    rf_val[6] = 32'h22;
    reset_n = 1'b0; flush = 1'b0; iss_ready = 1'b0;
    dec_valid = 1'b0;
    dec_put(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    dec_valid = 1'b0;
    wb_put(1'b0, 5'd0, 2'd0, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_dec_ready", 32'(dec_ready), 32'd1);
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_rd_en", 32'({rf_rd_ch0_en, rf_rd_ch1_en}), 32'd0);
    check("rst_inv_en", 32'(rf_invalid_en), 32'd0);
    check("rst_payload", iss_payload, 32'd0);
    check("rst_rs1", iss_rs1_data, 32'd0);
    reset_n = 1'b1;
    step();

    // Clean operands: two-cycle latency, invalidate x7 with new tag 1
    iss_ready = 1'b1;
    dec_put(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 32'hCAFE0001);
    #1;
    check("t1_dec_ready", 32'(dec_ready), 32'd1);
    step();
    dec_valid = 1'b0;
    #1;
    check("t1_wait_valid", 32'(iss_valid), 32'd0);
    check("t1_wait_rd", 32'({rf_rd_ch0_en, rf_rd_ch1_en}), 32'd3);
    check("t1_wait_addr", 32'({rf_rd_ch0_addr, rf_rd_ch1_addr}), 32'({5'd5, 5'd6}));
    check("t1_wait_dec_ready", 32'(dec_ready), 32'd0);
    step();
    check("t1_iss_valid", 32'(iss_valid), 32'd1);
    check("t1_rs1", iss_rs1_data, 32'h11);
    check("t1_rs2", iss_rs2_data, 32'h22);
    check("t1_inv_en", 32'(rf_invalid_en), 32'd1);
    check("t1_inv_addr", 32'(rf_invalid_addr), 32'd7);
    check("t1_rd_tag", 32'(iss_rd_tag), 32'd1);
    check("t1_payload", iss_payload, 32'hCAFE0001);
    check("t1_rd", 32'({iss_rd_en, iss_rd_addr}), 32'({1'b1, 5'd7}));
    step();
    check("t1_idle_valid", 32'(iss_valid), 32'd0);
    check("t1_idle_ready", 32'(dec_ready), 32'd1);

    // Dirty x5 tag 1, write-back arrives after three waiting cycles
    rf_dirty[5] = 1'b1; rf_tag[5] = 2'd1;
    dec_put(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd8, 32'h2);
    step();
    dec_valid = 1'b0;
    #1;
    check("t2_rd_en", 32'({rf_rd_ch0_en, rf_rd_ch1_en}), 32'd2);
    for (int c = 0; c < 3; c++) begin
      check("t2_waiting", 32'(iss_valid), 32'd0);
      step();
    end
    wb_put(1'b1, 5'd5, 2'd1, 32'hAB);
    #1;
    check("t2_wb_cycle_valid", 32'(iss_valid), 32'd0);
    step();
    wb_put(1'b0, 5'd0, 2'd0, 32'd0);
    #1;
    check("t2_iss_valid", 32'(iss_valid), 32'd1);
    check("t2_rs1_fwd", iss_rs1_data, 32'hAB);
    check("t2_rs2_unused", iss_rs2_data, 32'd0);
    check("t2_rd_tag", 32'(iss_rd_tag), 32'd1);
    step();

    // Tag mismatch ignored, later matching write-back forwarded; rd=x0 never invalidates
    rf_dirty[5] = 1'b1; rf_tag[5] = 2'd1;
    dec_put(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 32'h3);
    step();
    dec_valid = 1'b0;
    wb_put(1'b1, 5'd5, 2'd0, 32'hDEAD);
    #1;
    check("t3_stale_valid", 32'(iss_valid), 32'd0);
    step();
    wb_put(1'b0, 5'd0, 2'd0, 32'd0);
    #1;
    check("t3_still_wait", 32'(iss_valid), 32'd0);
    check("t3_rd_en", 32'({rf_rd_ch0_en, rf_rd_ch1_en}), 32'd2);
    step();
    wb_put(1'b1, 5'd5, 2'd1, 32'h55);
    step();
    wb_put(1'b0, 5'd0, 2'd0, 32'd0);
    #1;
    check("t3_iss_valid", 32'(iss_valid), 32'd1);
    check("t3_rs1", iss_rs1_data, 32'h55);
    check("t3_rs2", iss_rs2_data, 32'h22);
    check("t3_x0_no_inv", 32'(rf_invalid_en), 32'd0);
    check("t3_x0_tag", 32'(iss_rd_tag), 32'd0);
    step();

    // rd==rs: old value issued, follower waits on the new tag then forwards
    rf_val[5] = 32'h10;
    dec_put(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 32'h4A);
    step();
    dec_valid = 1'b0;
    step();
    dec_put(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd9, 32'h4B);
    #1;
    check("t4a_valid", 32'(iss_valid), 32'd1);
    check("t4a_rs1_old", iss_rs1_data, 32'h10);
    check("t4a_inv", 32'({rf_invalid_en, rf_invalid_addr}), 32'({1'b1, 5'd5}));
    check("t4a_rd_tag", 32'(iss_rd_tag), 32'd2);
    check("t4a_dec_ready", 32'(dec_ready), 32'd1);
    step();
    dec_valid = 1'b0;
    #1;
    check("t4b_wait_valid", 32'(iss_valid), 32'd0);
    check("t4b_wait_rd", 32'(rf_rd_ch0_en), 32'd1);
    step();
    check("t4b_still_wait", 32'(iss_valid), 32'd0);
    wb_put(1'b1, 5'd5, 2'd2, 32'h77);
    step();
    wb_put(1'b0, 5'd0, 2'd0, 32'd0);
    #1;
    check("t4b_valid", 32'(iss_valid), 32'd1);
    check("t4b_rs1_fwd", iss_rs1_data, 32'h77);
    check("t4b_payload", iss_payload, 32'h4B);
    check("t4b_rd_tag", 32'(iss_rd_tag), 32'd1);
    step();

    // Execute stall: outputs held, no invalidate until the handshake, then one pulse
    iss_ready = 1'b0;
    dec_put(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd10, 32'h5555);
    step();
    dec_valid = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      check("t5_hold_valid", 32'(iss_valid), 32'd1);
      check("t5_hold_data", iss_rs1_data ^ iss_rs2_data ^ iss_payload, 32'h5555);
      check("t5_hold_rd", 32'({iss_rd_en, iss_rd_addr}), 32'({1'b1, 5'd10}));
      check("t5_hold_ready", 32'(dec_ready), 32'd0);
      check("t5_hold_inv", 32'(rf_invalid_en), 32'd0);
      step();
    end
    iss_ready = 1'b1;
    #1;
    check("t5_inv", 32'({rf_invalid_en, rf_invalid_addr}), 32'({1'b1, 5'd10}));
    check("t5_rd_tag", 32'(iss_rd_tag), 32'd1);
    step();
    check("t5_single_pulse", 32'(rf_invalid_en), 32'd0);
    check("t5_idle", 32'(iss_valid), 32'd0);

    // Flush in WAIT
    rf_dirty[11] = 1'b1; rf_tag[11] = 2'd3;
    dec_put(1'b1, 5'd11, 1'b0, 5'd0, 1'b1, 5'd12, 32'h6);
    step();
    dec_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("t6a_flush_ready", 32'(dec_ready), 32'd0);
    check("t6a_flush_inv", 32'(rf_invalid_en), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("t6a_idle_valid", 32'(iss_valid), 32'd0);
    check("t6a_idle_ready", 32'(dec_ready), 32'd1);
    check("t6a_idle_rd", 32'(rf_rd_ch0_en), 32'd0);

    // Flush in ISSUE with execute ready and a new instruction offered
    dec_put(1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd13, 32'h7);
    step();
    dec_valid = 1'b0;
    step();
    flush = 1'b1;
    dec_put(1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd14, 32'h8);
    #1;
    check("t6b_valid_before", 32'(iss_valid), 32'd1);
    check("t6b_no_inv", 32'(rf_invalid_en), 32'd0);
    check("t6b_no_accept", 32'(dec_ready), 32'd0);
    check("t6b_tag", 32'(iss_rd_tag), 32'd0);
    step();
    flush = 1'b0;
    dec_valid = 1'b0;
    #1;
    check("t6b_valid_after", 32'(iss_valid), 32'd0);
    check("t6b_ready_after", 32'(dec_ready), 32'd1);
    check("t6b_not_wait", 32'(rf_rd_ch0_en), 32'd0);

    // Asynchronous reset while waiting
    dec_put(1'b1, 5'd11, 1'b0, 5'd0, 1'b1, 5'd15, 32'h9);
    step();
    dec_valid = 1'b0;
    #1;
    check("t6c_wait_rd", 32'(rf_rd_ch0_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6c_rst_rd", 32'(rf_rd_ch0_en), 32'd0);
    check("t6c_rst_valid", 32'(iss_valid), 32'd0);
    check("t6c_rst_ready", 32'(dec_ready), 32'd1);
    check("t6c_rst_payload", iss_payload, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("t6c_post_valid", 32'(iss_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
